hazard_tracker: RTL and testbench
=================================

Name: hazard_tracker

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; it is the other end of the execute stage's hazard interface.
- Consumes Rs1E/Rs2E and PCSrcE from execute and decode-stage register fields.
- Produces ForwardAE/ForwardBE, stall and flush controls.
- Keeps its own shadow pipeline of destination-register info (E→M→W), mirroring the datapath pipeline registers, so it needs no RdM/RdW feeds. Also keeps stall/flush event counters for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, width of each perf counter

Ports:
- clk_i  in  1  core clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- Rs1D_i  in  5  decode-stage source 1
- Rs2D_i  in  5  decode-stage source 2
- RdD_i  in  5  decode-stage destination
- RegWriteD_i  in  1  decode-stage instruction writes rd
- ResultSrcD_i  in  2  decode-stage result select; 2'b01 = load
- Rs1E_i  in  5  execute-stage source 1 (from execute Rs1E_o)
- Rs2E_i  in  5  execute-stage source 2 (from execute Rs2E_o)
- PCSrcE_i  in  1  execute redirect (taken branch or jump)
- ForwardAE_o  out  2  00 = reg file, 01 = ResultW, 10 = ALUResultM
- ForwardBE_o  out  2  same encoding as ForwardAE_o, for operand B
- StallF_o  out  1  hold PC
- StallD_o  out  1  hold IF/ID register
- FlushD_o  out  1  clear IF/ID register
- FlushE_o  out  1  clear ID/EX register (bubble)
- StallCount_o  out  CNT_WIDTH  cycles with StallD_o = 1
- FlushCount_o  out  CNT_WIDTH  cycles with PCSrcE_i = 1

Behaviour:
- Shadow stages E, M, W each hold {rd, regwrite, isload}. Reset: all fields 0. Writes to x0 are treated as no-write everywhere.
- Each clock edge:
  - E ← D fields, or all-zero bubble when FlushE_o = 1.
  - M ← E.
  - W ← M.
  - There is no stall of E/M/W; this matches the datapath, which stalls only F and D.
- Forwarding is combinational and evaluated for A with Rs1E_i and for B with Rs2E_i:
  - 10 if M.regwrite && !M.isload && M.rd != 0 && M.rd == RsXE;
  - else 01 if W.regwrite && W.rd != 0 && W.rd == RsXE;
  - else 00.
  - M has priority over W (newest value wins).
- Load-use detection: lwStall = E.isload && E.regwrite && E.rd != 0 && (E.rd == Rs1D_i || E.rd == Rs2D_i).
  - Rs2D_i is compared even for I-type instructions; the conservative stall is accepted.
- Control outputs:
  - StallF_o = StallD_o = lwStall && !PCSrcE_i. A redirect overrides the stall, because the stalled instruction is being squashed anyway.
  - FlushD_o = PCSrcE_i.
  - FlushE_o = lwStall || PCSrcE_i.
- Load-use latency: exactly one bubble.
  - Cycle t: load in E, consumer in D; stall asserted.
  - Cycle t+1: load in M, bubble in E.
  - Cycle t+2: load in W, consumer in E; ForwardXE = 01.
- Counters: synchronous increment; wrap at 2^CNT_WIDTH with no saturation; reset to 0.
- Reset mid-operation: asynchronous clear of all shadow state and counters; outputs return to 00/0 immediately.
- All outputs are 00/0 during reset.

Decomposition:
- Shared package core_pkg holds:
  - forward-select constants FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - RESULT_SRC_LOAD = 2'b01;
  - packed struct hz_stage_t {rd, regwrite, isload}.
- One sub-module, hazard_fwd_sel: a combinational per-operand forwarding comparator, instantiated twice (A and B).

Test Plan:
- add x5 followed by sub using x5 as rs1 → next cycle ForwardAE_o = 10; one cycle later a dependent rs2 sees ForwardBE_o = 01.
- lw x6 in E with RdD-stage consumer Rs2D_i = 6 → StallF_o = StallD_o = FlushE_o = 1 for exactly one cycle; two cycles later ForwardBE_o = 01; StallCount_o = 1.
- Writes to x0: addi x0 followed by a consumer of x0 → ForwardAE_o/ForwardBE_o stay 00. lw x0 followed by a consumer of x0 → no stall.
- Load-use stall coincident with PCSrcE_i = 1 → StallF_o = 0, FlushD_o = 1, FlushE_o = 1, FlushCount_o increments by 1.
- Both M and W target x7 and Rs1E_i = 7 → ForwardAE_o = 10 (M priority).
- Assert rst_n_i low mid-stall → outputs 0 asynchronously, counters 0, a dependent instruction after release → ForwardXE = 00.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core's hazard control: forward-select codes,
// the load result-select code and the shadow pipeline stage record.
package core_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam int HZ_REG_W = 5;

    typedef struct packed {
        logic [HZ_REG_W-1:0] rd;
        logic                regwrite;
        logic                isload;
    } hz_stage_t;

    localparam hz_stage_t HZ_BUBBLE = '{rd: 5'd0, regwrite: 1'b0, isload: 1'b0};

    // True when the stage really updates an architectural register (x0 never counts).
    function automatic logic hz_writes(input hz_stage_t s);
        return s.regwrite && (s.rd != {HZ_REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: picks ALUResultM, ResultW or the register file
// for one execute-stage source register. The memory stage wins over writeback
// because it holds the newer value; loads in M have no data yet, so they never
// forward from M.
module hazard_fwd_sel
    import core_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  hz_stage_t                 stage_m,
    input  hz_stage_t                 stage_w,
    input  logic [REG_ADDR_WIDTH-1:0] rs_e,
    output logic [1:0]                fwd
);

    // Priority compare of the execute source against the M then W shadow stages.
    always_comb begin
        fwd = FWD_REG;
        if (hz_writes(stage_m) && !stage_m.isload && (stage_m.rd == rs_e)) begin
            fwd = FWD_MEM;
        end else if (hz_writes(stage_w) && (stage_w.rd == rs_e)) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard controller for the 5-stage RV32 core. Tracks destination-register
// info through its own E/M/W shadow pipeline, generates operand forwarding,
// load-use stalls and redirect flushes, and counts stall/flush cycles.
module hazard_tracker
    import core_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdD_i,
    input  logic                      RegWriteD_i,
    input  logic [1:0]                ResultSrcD_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic                      PCSrcE_i,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic [CNT_WIDTH-1:0]      StallCount_o,
    output logic [CNT_WIDTH-1:0]      FlushCount_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    hz_stage_t stage_d_s;
    hz_stage_t stage_e_r;
    hz_stage_t stage_m_r;
    hz_stage_t stage_w_r;

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       lw_stall_s;
    logic       stall_s;
    logic       flush_e_s;

    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;

    // Decode-stage record; a write to x0 is folded into "no write" right here.
    always_comb begin
        stage_d_s.rd       = RdD_i;
        stage_d_s.regwrite = RegWriteD_i && (RdD_i != {REG_ADDR_WIDTH{1'b0}});
        stage_d_s.isload   = stage_d_s.regwrite && (ResultSrcD_i == RESULT_SRC_LOAD);
    end

    hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .stage_m (stage_m_r),
        .stage_w (stage_w_r),
        .rs_e    (Rs1E_i),
        .fwd     (fwd_a_s)
    );

    hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .stage_m (stage_m_r),
        .stage_w (stage_w_r),
        .rs_e    (Rs2E_i),
        .fwd     (fwd_b_s)
    );

    // Load-use detection and stall/flush resolution; a redirect squashes the
    // stalled instruction, so it overrides the stall.
    always_comb begin
        lw_stall_s = 1'b0;
        if (stage_e_r.isload && hz_writes(stage_e_r) &&
            ((stage_e_r.rd == Rs1D_i) || (stage_e_r.rd == Rs2D_i))) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
        stall_s   = lw_stall_s && !PCSrcE_i;
        flush_e_s = lw_stall_s || PCSrcE_i;
    end

    // Output drive; everything is held at 0 while reset is asserted.
    always_comb begin
        ForwardAE_o = FWD_REG;
        ForwardBE_o = FWD_REG;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        if (rst_n_i) begin
            ForwardAE_o = fwd_a_s;
            ForwardBE_o = fwd_b_s;
            StallF_o    = stall_s;
            StallD_o    = stall_s;
            FlushD_o    = PCSrcE_i;
            FlushE_o    = flush_e_s;
        end else begin
            ForwardAE_o = FWD_REG;
            ForwardBE_o = FWD_REG;
        end
    end

    // Shadow E/M/W pipeline; only E can take a bubble, nothing here stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_e_r <= HZ_BUBBLE;
            stage_m_r <= HZ_BUBBLE;
            stage_w_r <= HZ_BUBBLE;
        end else begin
            if (flush_e_s) begin
                stage_e_r <= HZ_BUBBLE;
            end else begin
                stage_e_r <= stage_d_s;
            end
            stage_m_r <= stage_e_r;
            stage_w_r <= stage_m_r;
        end
    end

    // Free-running wrap-around performance counters for stall and redirect cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (PCSrcE_i) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCount_o = stall_cnt_r;
    assign FlushCount_o = flush_cnt_r;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: each step drives decode/execute fields,
// queues the expected control word and compares it on the falling edge.
module tb_hazard_tracker;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  Rs1D_i, Rs2D_i, RdD_i, Rs1E_i, Rs2E_i;
    logic        RegWriteD_i;
    logic [1:0]  ResultSrcD_i;
    logic        PCSrcE_i;
    logic [1:0]  ForwardAE_o, ForwardBE_o;
    logic        StallF_o, StallD_o, FlushD_o, FlushE_o;
    logic [31:0] StallCount_o, FlushCount_o;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    hazard_tracker #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .Rs1D_i       (Rs1D_i),
        .Rs2D_i       (Rs2D_i),
        .RdD_i        (RdD_i),
        .RegWriteD_i  (RegWriteD_i),
        .ResultSrcD_i (ResultSrcD_i),
        .Rs1E_i       (Rs1E_i),
        .Rs2E_i       (Rs2E_i),
        .PCSrcE_i     (PCSrcE_i),
        .ForwardAE_o  (ForwardAE_o),
        .ForwardBE_o  (ForwardBE_o),
        .StallF_o     (StallF_o),
        .StallD_o     (StallD_o),
        .FlushD_o     (FlushD_o),
        .FlushE_o     (FlushE_o),
        .StallCount_o (StallCount_o),
        .FlushCount_o (FlushCount_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb,
                                input logic st, input logic fd, input logic fe);
        exp_t e;
        e.fa = fa; e.fb = fb; e.sf = st; e.sd = st; e.fd = fd; e.fe = fe;
        return e;
    endfunction

    task automatic drive(input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rdd, input logic rwd, input logic [1:0] rsd,
                         input logic [4:0] rs1e, input logic [4:0] rs2e,
                         input logic pcs, input exp_t e);
        Rs1D_i = rs1d; Rs2D_i = rs2d; RdD_i = rdd;
        RegWriteD_i = rwd; ResultSrcD_i = rsd;
        Rs1E_i = rs1e; Rs2E_i = rs2e; PCSrcE_i = pcs;
        sb_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        exp_t o;
        o = {ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, FlushD_o, FlushE_o};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%b", tag, o);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed fa/fb/sf/sd/fd/fe=%b expected=%b", tag, o, e);
            end
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
        checks++;
        assert ((StallCount_o === st) && (FlushCount_o === fl)) else begin
            errors++;
            $error("FAIL %s observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, StallCount_o, FlushCount_o, st, fl);
        end
    endtask

    // One pipeline cycle: drive, compare on the falling edge, advance past the rising edge.
    task automatic step(input string tag, input logic [4:0] rs1d, input logic [4:0] rs2d,
                        input logic [4:0] rdd, input logic rwd, input logic [1:0] rsd,
                        input logic [4:0] rs1e, input logic [4:0] rs2e,
                        input logic pcs, input exp_t e);
        drive(rs1d, rs2d, rdd, rwd, rsd, rs1e, rs2e, pcs, e);
        @(negedge clk_i);
        check(tag);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with a redirect and matching sources presented: everything must read 0.
        rst_n_i = 1'b0;
        drive(5'd3, 5'd3, 5'd3, 1'b1, 2'b01, 5'd3, 5'd3, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        #3;
        check("reset_outputs");
        @(posedge clk_i);
        #1;
        chk_cnt("reset_counters", 32'd0, 32'd0);
        rst_n_i = 1'b1;
        PCSrcE_i = 1'b0;

        // add x5 ; sub x8,x5,x1 ; or x9,x2,x5 ; nop
        step("add_x5",      5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("sub_in_d",    5'd5, 5'd1, 5'd8, 1'b1, 2'b00, 5'd1, 5'd2, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("fwd_a_mem",   5'd2, 5'd5, 5'd9, 1'b1, 2'b00, 5'd5, 5'd1, 1'b0, ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0));
        step("fwd_b_wb",    5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd2, 5'd5, 1'b0, ex(2'b00, 2'b01, 1'b0, 1'b0, 1'b0));

        // lw x6 ; add x10,x1,x6 -> one bubble then writeback forward on B
        step("lw_x6",       5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("lu_stall",    5'd1, 5'd6, 5'd10, 1'b1, 2'b00, 5'd3, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
        chk_cnt("stall_count_1", 32'd1, 32'd0);
        step("lu_bubble",   5'd1, 5'd6, 5'd10, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("lu_fwd_wb",   5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd1, 5'd6, 1'b0, ex(2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
        chk_cnt("stall_count_hold", 32'd1, 32'd0);

        // Writes to x0: addi x0 ; lw x0 ; consumer of x0
        step("addi_x0",     5'd1, 5'd0, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("lw_x0",       5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 5'd1, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("x0_no_stall", 5'd0, 5'd0, 5'd11, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("x0_no_fwd_w", 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

        // Load-use stall coincident with a redirect
        step("lw_x12",      5'd0, 5'd0, 5'd12, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("lu_redirect", 5'd12, 5'd0, 5'd13, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
        chk_cnt("flush_count_1", 32'd1, 32'd1);
        step("after_redir", 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

        // addi x7 ; addi x7 -> M and W both hold x7
        step("addi_x7_a",   5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("addi_x7_b",   5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("x7_m_only",   5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd7, 5'd12, 1'b0, ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0));
        step("x7_m_prio",   5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd7, 5'd7, 1'b0, ex(2'b10, 2'b10, 1'b0, 1'b0, 1'b0));
        step("x7_w_only",   5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd7, 5'd0, 1'b0, ex(2'b01, 2'b00, 1'b0, 1'b0, 1'b0));

        // Reset asserted in the middle of a load-use stall
        step("lw_x14",      5'd0, 5'd0, 5'd14, 1'b1, 2'b01, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        drive(5'd0, 5'd14, 5'd15, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
        @(negedge clk_i);
        check("stall_pre_rst");
        #1;
        rst_n_i = 1'b0;
        drive(5'd0, 5'd14, 5'd15, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        check("async_rst_out");
        chk_cnt("async_rst_cnt", 32'd0, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        PCSrcE_i = 1'b0;
        step("post_rst_dep", 5'd14, 5'd14, 5'd0, 1'b0, 2'b00, 5'd14, 5'd14, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("post_rst_e",   5'd14, 5'd7, 5'd0, 1'b0, 2'b00, 5'd14, 5'd7, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        chk_cnt("post_rst_cnt", 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
